register_dispatch: RTL and testbench
====================================

Name: register_dispatch

Overview:
- Write-side counterpart of the datapath's 4-input load-select register.
- Accepts one n-bit value plus a 2-bit destination select per transfer and delivers it to exactly one of four destination ports over a valid/ready handshake.
- A 2-entry in-order buffer decouples the producer from slow destinations.
- Sits between a datapath result register and up to four consumer units.

Parameters:
- n, `DEFAULT_WIDTH, data width of every data port.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  producer offers in_data/in_select this cycle.
- in_ready  output  1  dispatcher can accept an entry this cycle.
- in_select  input  2  destination index 0..3.
- in_data  input  n  value to deliver.
- out_valid  output  4  one-hot; bit k = head entry destined for port k.
- out_ready  input  4  bit k = destination k accepts this cycle.
- out0, out1, out2, out3  output  n each  delivery data per destination.
- count  output  2  number of buffered entries, 0..2.

Behaviour:
- Storage: 2-entry circular buffer of {select, data}, head pointer, tail pointer, 2-bit occupancy count. All registered.
- Reset (reset==0, asynchronous): count=0, pointers=0, entry contents=0. Resulting outputs: out_valid=4'b0000, out0..out3=0, in_ready=1, count=0. Reset mid-transfer discards all entries with no partial delivery.
- in_ready = (count != 2). Derived from state only; never from out_ready or in_valid.
- Accept: in_valid && in_ready at a rising edge. Writes {in_select, in_data} at the tail; tail increments modulo 2.
- Head presentation:
  - count>0: out_valid has exactly one bit set, at index head.select.
  - count==0: out_valid=0.
  - outk = head.data when out_valid[k]==1, else 0. Unselected ports are always 0.
- Deliver: out_valid[k] && out_ready[k] at a rising edge pops the head; head increments modulo 2. out_ready bits for non-valid ports are ignored.
- Latency: an entry accepted at edge t into an empty buffer drives out_valid from after edge t. Delivered at earliest at edge t+1.
- Back-to-back throughput: one entry per cycle when the destination holds out_ready=1.
- Occupancy update:
  - Accept only: count+1.
  - Deliver only: count-1.
  - Both in the same cycle (count==1): count unchanged, new head = the accepted entry.
  - Accept while full cannot occur, because in_ready=0.
- Ordering: strictly in acceptance order, regardless of destination. A stalled destination blocks entries behind it (head-of-line blocking is intended).
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_valid and outk hold unchanged.
- flush (reset==1): at the rising edge, count=0 and head=tail=0.
  - An accept or deliver in the same cycle is discarded.
  - A delivery handshake coinciding with flush is not considered performed.
  - in_ready during the flush cycle follows the pre-flush count.
- Pointer wrap: pointers are 1 bit and wrap 1->0 silently. Full/empty are determined by count, never by pointer compare.
- in_select, in_data and out_ready are don't-care when their qualifying valid is low.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> out_valid=0000, out0..3=0, in_ready=1, count=0.
- Single delivery: accept {sel=2, data=0xA5}, out_ready=0100 -> next cycle out_valid=0100, out2=0xA5, out0/1/3=0. Pops at the following edge, count returns to 0.
- Fill and stall: accept {0,0x11} then {3,0x22} with out_ready=0000 -> count=2, in_ready=0, out_valid=0001 held 5 cycles. Raise out_ready[0] -> out_valid=1000, out3=0x22. Then count=0.
- Simultaneous push/pop at count=1: head {1,0x33} delivered while {1,0x44} accepted -> count stays 1, out1=0x44 next cycle. Streaming 8 entries with out_ready=1111 delivers one per cycle, in order, exercising pointer wrap.
- Wrong-port ready ignored: head {2,0x55}, out_ready=1011 for 3 cycles -> no pop, count unchanged, out2=0x55 stable.
- Flush and mid-operation reset:
  - count=2 with flush=1 together with in_valid=1 -> count=0, out_valid=0000 next cycle; the pushed entry is lost.
  - Separately, reset asserted mid-stream between edges -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_dispatch.sv
// register_dispatch: routes each accepted {select, data} transfer to one of
// four destination ports through a 2-entry in-order buffer. Entries leave
// strictly in acceptance order. A stalled destination holds up every entry
// queued behind it.

`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

// One destination port. It masks the head data onto its port and reports
// whether this port completed the handshake this cycle.
module register_dispatch_lane #(
    parameter int n = `DEFAULT_WIDTH
) (
    input  logic         valid,
    input  logic         ready,
    input  logic [n-1:0] head_data,
    output logic [n-1:0] data,
    output logic         fire
);

    // An unselected port always shows zero, so only the addressed consumer
    // sees a value.
    always_comb begin
        data = valid ? head_data : '0;
        fire = valid & ready;
    end

endmodule

module register_dispatch #(
    parameter int n = `DEFAULT_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_select,
    input  logic [n-1:0] in_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [n-1:0] out0,
    output logic [n-1:0] out1,
    output logic [n-1:0] out2,
    output logic [n-1:0] out3,
    output logic [1:0]   count
);

    localparam int NUM_LANES = 4;
    localparam int DEPTH     = 2;

    typedef struct packed {
        logic [1:0]   sel;
        logic [n-1:0] data;
    } entry_t;

    entry_t                          entries [DEPTH];
    logic                            head;
    logic                            tail;
    logic [1:0]                      occ;
    entry_t                          head_entry;
    logic                            accept;
    logic                            deliver;
    logic [NUM_LANES-1:0]            fire;
    logic [NUM_LANES-1:0][n-1:0]     lane_data;

    // Full and empty come from the occupancy count, never from comparing
    // pointers. Both pointers are 1 bit and wrap on their own.
    always_comb begin
        head_entry = entries[head];
        in_ready   = (occ != 2'd2);
        accept     = in_valid & in_ready;
        out_valid  = (occ != 2'd0) ? (4'b0001 << head_entry.sel) : 4'b0000;
        deliver    = |fire;
        count      = occ;
    end

    // The per-port masking and handshake detection are replicated once for
    // each destination.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        register_dispatch_lane #(.n(n)) u_lane (
            .valid     (out_valid[k]),
            .ready     (out_ready[k]),
            .head_data (head_entry.data),
            .data      (lane_data[k]),
            .fire      (fire[k])
        );
    end

    assign out0 = lane_data[0];
    assign out1 = lane_data[1];
    assign out2 = lane_data[2];
    assign out3 = lane_data[3];

    // Buffer state. flush empties the buffer and drops any accept or
    // delivery in the same cycle. A simultaneous push and pop keeps the
    // count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            occ  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
        end else begin
            if (accept) begin
                entries[tail] <= '{sel: in_select, data: in_data};
                tail          <= ~tail;
            end
            if (deliver) head <= ~head;
            case ({accept, deliver})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_dispatch.sv
// Directed bench for register_dispatch. Stimulus is applied 1 ns after each
// rising edge. Outputs are checked at that same point, after the edge's
// state update.
module tb_register_dispatch;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_select;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out0, out1, out2, out3;
    logic [1:0] count;

    int checks = 0;
    int fails  = 0;

    register_dispatch #(.n(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_select (in_select),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Checks the full visible output state against hand-computed values.
    task automatic chk_all(input string tag, input logic [3:0] v, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                           input logic rdy, input logic [1:0] c);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out0"}, 32'(out0), 32'(d0));
        chk({tag, ".out1"}, 32'(out1), 32'(d1));
        chk({tag, ".out2"}, 32'(out2), 32'(d2));
        chk({tag, ".out3"}, 32'(out3), 32'(d3));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".count"}, 32'(count), 32'(c));
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] d);
        in_valid = 1'b1; in_select = s; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_select = 2'd0;
        in_data = 8'h00; out_ready = 4'b0000;

        // Reset, then idle
        step(); step();
        chk_all("in_reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);
        reset = 1'b1;
        step();
        chk_all("idle", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);

        // Single delivery to port 2
        out_ready = 4'b0100;
        push(2'd2, 8'hA5);
        chk_all("single", 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, 2'd1);
        step();
        chk_all("single_pop", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);

        // Fill and stall. Offers made while full must not enter the buffer.
        out_ready = 4'b0000;
        push(2'd0, 8'h11);
        push(2'd3, 8'h22);
        chk_all("full", 4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2);
        in_valid = 1'b1; in_select = 2'd1; in_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("stall", 4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 1'b0, 2'd2);
        end
        in_valid = 1'b0;
        out_ready = 4'b0001;
        step();
        chk_all("drain1", 4'b1000, 8'h00, 8'h00, 8'h00, 8'h22, 1'b1, 2'd1);
        out_ready = 4'b1000;
        step();
        chk_all("drain2", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);

        // Push and pop in the same cycle at count 1
        out_ready = 4'b0000;
        push(2'd1, 8'h33);
        chk_all("pp_head", 4'b0010, 8'h00, 8'h33, 8'h00, 8'h00, 1'b1, 2'd1);
        out_ready = 4'b0010;
        push(2'd1, 8'h44);
        chk_all("pp_same", 4'b0010, 8'h00, 8'h44, 8'h00, 8'h00, 1'b1, 2'd1);
        step();
        chk("pp_empty.count", 32'(count), 32'd0);

        // Stream 8 entries with every destination ready. Each edge retires the
        // previous entry and accepts the next, and the pointers wrap.
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            push(2'(i % 4), 8'(8'h60 + i));
            chk("stream.count", 32'(count), 32'd1);
            chk("stream.valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            chk("stream.data", 32'(out0 | out1 | out2 | out3), 32'(8'h60 + i));
        end
        step();
        chk("stream_end.count", 32'(count), 32'd0);

        // A ready on a port other than the head's port is ignored
        out_ready = 4'b0000;
        push(2'd2, 8'h55);
        out_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("wrongport", 4'b0100, 8'h00, 8'h00, 8'h55, 8'h00, 1'b1, 2'd1);
        end
        out_ready = 4'b0100;
        step();
        chk("wrongport_pop.count", 32'(count), 32'd0);

        // Flush at count 2 with a push offer and readies raised. Everything is
        // dropped. in_ready still reflects the pre-flush full state.
        out_ready = 4'b0000;
        push(2'd0, 8'h66);
        push(2'd1, 8'h77);
        flush = 1'b1; in_valid = 1'b1; in_select = 2'd2; in_data = 8'h88;
        out_ready = 4'b1111;
        #1;
        chk("flush_cycle.in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
        chk_all("flushed", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);
        step();
        chk("flushed_lost.count", 32'(count), 32'd0);

        // Flush at count 1 with an acceptable push. The push is still dropped.
        push(2'd3, 8'h5A);
        flush = 1'b1; in_valid = 1'b1; in_select = 2'd0; in_data = 8'hC3;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_all("flush1", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);

        // Reset asserted between edges takes effect immediately
        push(2'd3, 8'hAB);
        chk("pre_reset.out3", 32'(out3), 32'h0AB);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);
        step();
        reset = 1'b1;
        step();
        chk_all("post_reset", 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
